// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions: register numbers, exception codes,
// SR/Cause field layout and small helpers used by the CP0 block.
package cp0_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Exception codes carried in Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Field positions inside the architectural 32-bit views
  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IE_BIT     = 0;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  // Only the implemented SR bits are stored
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  // Only the implemented Cause bits are stored
  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  // Architectural 32-bit view of SR; unimplemented bits read as zero
  function automatic logic [31:0] sr_word(input sr_t s);
    logic [31:0] w;
    w                      = '0;
    w[SR_IM_LSB +: 6]      = s.im;
    w[SR_EXL_BIT]          = s.exl;
    w[SR_IE_BIT]           = s.ie;
    return w;
  endfunction

  // Architectural 32-bit view of Cause; unimplemented bits read as zero
  function automatic logic [31:0] cause_word(input cause_t c);
    logic [31:0] w;
    w                         = '0;
    w[CAUSE_BD_BIT]           = c.bd;
    w[CAUSE_IP_LSB +: 6]      = c.ip;
    w[CAUSE_EXC_LSB +: 5]     = c.exc_code;
    return w;
  endfunction

  // Restart PC: a delay-slot instruction restarts at its branch; wraps mod 2^32
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return (bd ? pc - 32'd4 : pc) & ~32'h3;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// CP0 pipeline-side interface: mfc0/mtc0 access, M-stage exception inputs,
// interrupt lines and the exception request/redirect outputs.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] Din;
  logic        WE;
  logic [31:0] M_PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] Dout;
  logic [31:0] EPCOut;
  logic [31:0] ReqPC;
  logic        Req;

  // Pipeline side drives requests and consumes results
  modport master (
    output A1, A2, Din, WE, M_PC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  Dout, EPCOut, ReqPC, Req
  );

  // CP0 side
  modport slave (
    input  A1, A2, Din, WE, M_PC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output Dout, EPCOut, ReqPC, Req
  );
endinterface

// File: rtl/cp0_req_gen.sv
// CP0 request generator: decides in the current cycle whether the M-stage
// instruction is preempted by an interrupt or its own exception, and which
// ExcCode gets recorded.
module cp0_req_gen
  import cp0_pkg::*;
(
  input  sr_t        sr,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code_in,
  output logic       int_req,
  output logic       exc_req,
  output logic       req,
  output logic [4:0] next_exc_code
);

  // Combinational request decode; EXL blocks everything so handlers never nest
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    int_req       = 1'b0;
    exc_req       = 1'b0;
    req           = 1'b0;
    next_exc_code = EXC_INT;

    int_req = (|(hw_int & sr.im)) & sr.ie & ~sr.exl;
    exc_req = (exc_code_in != EXC_INT) & ~sr.exl;
    req     = int_req | exc_req;

    // An enabled interrupt outranks a synchronous exception in the same cycle
    if (!int_req) next_exc_code = exc_code_in;
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 exception/interrupt controller sitting beside the M stage.
// Holds SR, Cause, EPC and PRId, serves mfc0/mtc0, raises Req to flush the
// pipeline and redirect to HANDLER_ADDR, and clears EXL on eret.
// Optional build macro CP0_EPC_FWD_EN: forward an in-flight mtc0 EPC write
// onto EPCOut so an eret right behind it needs no stall.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h2022_1107
)(
  input  logic clk,
  input  logic reset,
  cp0_if.slave bus
);

  sr_t         sr;
  cause_t      cause;
  logic [31:0] epc;

  logic       int_req;
  logic       exc_req;
  logic       req;
  logic [4:0] next_exc_code;

  cp0_req_gen u_req_gen (
    .sr            (sr),
    .hw_int        (bus.HWInt),
    .exc_code_in   (bus.ExcCodeIn),
    .int_req       (int_req),
    .exc_req       (exc_req),
    .req           (req),
    .next_exc_code (next_exc_code)
  );

  // A taking exception kills the mtc0 in M, so its write must not land
  logic mtc0_sr;
  logic mtc0_epc;
  assign mtc0_sr  = bus.WE & ~req & (bus.A2 == REG_SR);
  assign mtc0_epc = bus.WE & ~req & (bus.A2 == REG_EPC);

  // CP0 state: reset, exception entry, then mtc0 / eret updates
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sr    <= '0;
      cause <= '0;
      epc   <= '0;
    end else begin
      cause.ip <= bus.HWInt;
      if (req) begin
        sr.exl         <= 1'b1;
        cause.bd       <= bus.BDIn;
        cause.exc_code <= next_exc_code;
        epc            <= epc_of(bus.M_PC, bus.BDIn);
      end else begin
        if (mtc0_sr) begin
          sr.im  <= bus.Din[SR_IM_LSB +: 6];
          sr.exl <= bus.Din[SR_EXL_BIT];
          sr.ie  <= bus.Din[SR_IE_BIT];
        end
        if (mtc0_epc) epc <= bus.Din;
        // Placed after the SR write so eret wins over a same-cycle mtc0 SR
        if (bus.EXLClr) sr.exl <= 1'b0;
      end
    end
  end

  // mfc0 read mux, combinational on A1
  always_comb begin
    bus.Dout = '0;
    case (bus.A1)
      REG_SR:    bus.Dout = sr_word(sr);
      REG_CAUSE: bus.Dout = cause_word(cause);
      REG_EPC:   bus.Dout = epc;
      REG_PRID:  bus.Dout = PRID_VALUE;
      default:   bus.Dout = '0;
    endcase
  end

  assign bus.Req   = req;
  assign bus.ReqPC = HANDLER_ADDR;

`ifdef CP0_EPC_FWD_EN
  assign bus.EPCOut = mtc0_epc ? bus.Din : epc;
`else
  assign bus.EPCOut = epc;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios followed by random
// traffic, all compared against a word-level model of the CP0 registers.
module tb_cp0_unit;
  import cp0_pkg::*;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h2022_1107;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  cp0_if bus ();

  cp0_unit #(.HANDLER_ADDR(HANDLER), .PRID_VALUE(PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state as architectural 32-bit words
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_int();
    return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((bus.ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_epcout();
`ifdef CP0_EPC_FWD_EN
    if (bus.WE && bus.A2 == 5'd14 && !m_req()) return bus.Din;
`endif
    return m_epc;
  endfunction

  // Apply the edge's effect to the model using the inputs still on the bus
  task automatic model_edge();
    logic [31:0] npc;
    logic [4:0]  code;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (m_req()) begin
      npc = bus.BDIn ? bus.M_PC - 32'd4 : bus.M_PC;
      npc[1:0] = 2'b00;
      code     = m_int() ? 5'd0 : bus.ExcCodeIn;
      m_epc    = npc;
      m_sr[1]  = 1'b1;
      m_cause  = {bus.BDIn, 15'b0, bus.HWInt, 3'b0, code, 2'b0};
    end else begin
      m_cause[15:10] = bus.HWInt;
      if (bus.WE && bus.A2 == 5'd12) m_sr = bus.Din & 32'h0000_FC03;
      if (bus.WE && bus.A2 == 5'd14) m_epc = bus.Din;
      if (bus.EXLClr) m_sr[1] = 1'b0;
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] a2,
                       input logic [31:0] din, input logic [31:0] pc, input logic bd,
                       input logic [4:0] exc, input logic [5:0] hw, input logic clr);
    reset = rst; bus.WE = we; bus.A2 = a2; bus.Din = din; bus.M_PC = pc;
    bus.BDIn = bd; bus.ExcCodeIn = exc; bus.HWInt = hw; bus.EXLClr = clr;
  endtask

  // One clock: check combinational outputs and all reads, then advance
  task automatic step(input string tag, input int exp_req);
    logic [4:0] a;
    #1;
    if (!reset) check({tag, "_req"}, {31'b0, bus.Req}, {31'b0, m_req()});
    if (exp_req >= 0) check({tag, "_req_dir"}, {31'b0, bus.Req}, exp_req[31:0]);
    check({tag, "_epcout"}, bus.EPCOut, m_epcout());
    for (int i = 0; i < 5; i++) begin
      a = (i < 4) ? 5'(12 + i) : 5'($urandom_range(0, 31));
      bus.A1 = a;
      #1;
      check($sformatf("%s_rd%0d", tag, a), bus.Dout, m_read(a));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.A1 = a;
    #1;
    check(tag, bus.Dout, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] din;
    logic [5:0]  hw;
    logic [4:0]  a2;
    m_sr = 0; m_cause = 0; m_epc = 0;
    bus.A1 = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst0", -1);
    step("rst1", -1);

    // Reset state
    drive(0, 0, 0, 0, 32'h3000, 0, 0, 0, 0);
    expect_reg("rst_sr", REG_SR, 32'h0);
    expect_reg("rst_cause", REG_CAUSE, 32'h0);
    expect_reg("rst_epc", REG_EPC, 32'h0);
    check("rst_epcout", bus.EPCOut, 32'h0);
    check("reqpc", bus.ReqPC, HANDLER);

    // 1: enable all interrupts, then raise one line
    drive(0, 1, REG_SR, 32'h0000_FC01, 32'h3000, 0, 0, 0, 0);
    step("t1_wsr", 0);
    drive(0, 0, 0, 0, 32'h3000, 0, 0, 6'b000100, 0);
    step("t1_int", 1);
    expect_reg("t1_sr", REG_SR, 32'h0000_FC03);
    expect_reg("t1_epc", REG_EPC, 32'h0000_3000);
    expect_reg("t1_cause", REG_CAUSE, 32'h0000_1000);

    // 2: overflow in a delay slot
    drive(0, 0, 0, 0, 32'h3004, 0, 0, 0, 1);
    step("t2_clr", 0);
    drive(0, 0, 0, 0, 32'h3008, 1, EXC_OV, 0, 0);
    step("t2_exc", 1);
    expect_reg("t2_epc", REG_EPC, 32'h0000_3004);
    expect_reg("t2_cause", REG_CAUSE, 32'h8000_0030);

    // 3: EXL masks both sources until eret clears it
    drive(0, 0, 0, 0, 32'h3010, 0, EXC_RI, 6'h3F, 0);
    step("t3_masked", 0);
    drive(0, 0, 0, 0, 32'h3014, 0, EXC_RI, 6'h3F, 1);
    step("t3_eret", 0);
    drive(0, 0, 0, 0, 32'h3020, 0, EXC_RI, 6'h3F, 0);
    step("t3_int", 1);
    expect_reg("t3_cause", REG_CAUSE, 32'h0000_FC00);

    // 4: mtc0 EPC dropped by a same-cycle exception
    drive(0, 0, 0, 0, 32'h3024, 0, 0, 0, 1);
    step("t4_clr", 0);
    drive(0, 1, REG_EPC, 32'h3100, 32'h3010, 0, EXC_ADEL, 0, 0);
    step("t4_exc", 1);
    expect_reg("t4_epc", REG_EPC, 32'h0000_3010);

    // 5: eret beats mtc0 SR; IM=0 blocks interrupts; IP and PRId reads
    drive(0, 1, REG_SR, 32'h0000_0003, 32'h3030, 0, 0, 0, 1);
    step("t5_wsr", 0);
    expect_reg("t5_sr", REG_SR, 32'h0000_0001);
    drive(0, 0, 0, 0, 32'h3034, 0, 0, 6'h3F, 0);
    step("t5_masked", 0);
    expect_reg("t5_cause", REG_CAUSE, 32'h0000_FC10);
    expect_reg("t5_prid", REG_PRID, PRID);

    // 6: EPCOut during an mtc0 EPC
    drive(0, 1, REG_EPC, 32'h3200, 32'h3038, 0, 0, 0, 0);
    #1;
`ifdef CP0_EPC_FWD_EN
    check("t6_same", bus.EPCOut, 32'h0000_3200);
`else
    check("t6_same", bus.EPCOut, 32'h0000_3010);
`endif
    step("t6_wepc", 0);
    check("t6_next", bus.EPCOut, 32'h0000_3200);

    // EPC wraps when a delay-slot instruction sits at address 0
    drive(0, 0, 0, 0, 32'h0, 1, EXC_ADES, 0, 0);
    step("wrap", 1);
    expect_reg("wrap_epc", REG_EPC, 32'hFFFF_FFFC);

    // Reset wins over exception, mtc0 and eret in the same cycle
    drive(0, 0, 0, 0, 32'h3040, 0, 0, 0, 1);
    step("mr_clr", 0);
    drive(0, 1, REG_SR, 32'h0000_FC01, 32'h3044, 0, 0, 0, 0);
    step("mr_wsr", 0);
    drive(1, 1, REG_SR, 32'hFFFF_FFFF, 32'h3048, 1, 5'd5, 6'h3F, 1);
    step("mr_rst", -1);
    drive(0, 0, 0, 0, 32'h304C, 0, 0, 0, 0);
    expect_reg("mr_sr", REG_SR, 32'h0);
    expect_reg("mr_cause", REG_CAUSE, 32'h0);
    expect_reg("mr_epc", REG_EPC, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       a2 = 5'd12;
        1:       a2 = 5'd13;
        2:       a2 = 5'd14;
        3:       a2 = 5'd15;
        default: a2 = 5'($urandom_range(0, 31));
      endcase
      din = $urandom;
      if (a2 == 5'd12 && $urandom_range(0, 3) != 0) din[1] = 1'b0;
      hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      drive($urandom_range(0, 60) == 0,
            $urandom_range(0, 2) == 0,
            a2, din, $urandom,
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            hw,
            $urandom_range(0, 4) == 0);
      step("rnd", -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
